// File: rtl/call_return_stack_pkg.sv
// Shared definitions for the return-address stack.
// The stack-op codes are formed as {call, ret}.
package call_return_stack_pkg;

  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_TAIL = 2'b11;

endpackage

// File: rtl/call_return_stack_crs_storage.sv
// Stack entry storage: DEPTH x ADDR_W register file with one synchronous
// write port and one combinational read port. Entries are never reset.
module crs_storage
  import call_return_stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/call_return_stack.sv
// Return-address stack feeding the PC's jump/custom_data inputs with zero
// latency; pointer, occupancy counter and sticky error flags live here.
module call_return_stack
  import call_return_stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              err_clr,
  output logic              jump_out,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  top_r;
  logic [CNT_W-1:0]  depth_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [1:0]        op_s;
  logic              full_s;
  logic              empty_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic [ADDR_W-1:0] rd_data_s;
  logic              jump_s;
  logic [ADDR_W-1:0] jump_addr_s;
  logic              we_s;
  logic [PTR_W-1:0]  waddr_s;
  logic [PTR_W-1:0]  top_nx_s;
  logic [CNT_W-1:0]  depth_nx_s;
  logic              ovf_set_s;
  logic              unf_set_s;

  assign op_s       = {call, ret};
  assign full_s     = (depth_r == CNT_W'(DEPTH));
  assign empty_s    = (depth_r == {CNT_W{1'b0}});
  assign ret_addr_s = pc_in + ADDR_W'(1);

  crs_storage #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (ret_addr_s),
    .raddr (top_r),
    .rdata (rd_data_s)
  );

  // jump mux, storage write control and next-state decode
  always_comb begin
    jump_s      = 1'b0;
    jump_addr_s = rd_data_s;
    we_s        = 1'b0;
    waddr_s     = top_r;
    top_nx_s    = top_r;
    depth_nx_s  = depth_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    case (op_s)
      OP_CALL: begin
        jump_s      = 1'b1;
        jump_addr_s = call_target;
        we_s        = 1'b1;
        waddr_s     = top_r + PTR_W'(1);
        top_nx_s    = top_r + PTR_W'(1);
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          depth_nx_s = depth_r + CNT_W'(1);
        end
      end
      OP_RET: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          jump_s     = 1'b1;
          top_nx_s   = top_r - PTR_W'(1);
          depth_nx_s = depth_r - CNT_W'(1);
        end
      end
      OP_TAIL: begin
        jump_s      = 1'b1;
        jump_addr_s = call_target;
        we_s        = 1'b1;
        // tail call on an empty stack has no frame to replace, so it pushes
        if (empty_s) begin
          waddr_s    = top_r + PTR_W'(1);
          top_nx_s   = top_r + PTR_W'(1);
          depth_nx_s = CNT_W'(1);
        end else begin
          waddr_s = top_r;
        end
      end
      default: begin
        jump_s = 1'b0;
      end
    endcase
  end

  // pointer, occupancy and sticky error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r       <= {PTR_W{1'b0}};
      depth_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      top_r       <= top_nx_s;
      depth_r     <= depth_nx_s;
      overflow_r  <= ovf_set_s | (overflow_r & ~err_clr);
      underflow_r <= unf_set_s | (underflow_r & ~err_clr);
    end
  end

  assign jump_out  = jump_s;
  assign jump_addr = jump_addr_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign depth     = depth_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_call_return_stack.sv
// Directed vector bench for call_return_stack (ADDR_W = 4, DEPTH = 4).
module tb_call_return_stack;

  logic       clk;
  logic       rst_n;
  logic [3:0] pc_in;
  logic       call;
  logic       ret;
  logic [3:0] call_target;
  logic       err_clr;
  logic       jump_out;
  logic [3:0] jump_addr;
  logic       full;
  logic       empty;
  logic [2:0] depth;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  call_return_stack #(.ADDR_W(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .call        (call),
    .ret         (ret),
    .call_target (call_target),
    .err_clr     (err_clr),
    .jump_out    (jump_out),
    .jump_addr   (jump_addr),
    .full        (full),
    .empty       (empty),
    .depth       (depth),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       call;
    logic       ret;
    logic [3:0] pc;
    logic [3:0] tgt;
    logic       clr;
    logic       e_jump;
    logic [3:0] e_addr;
    logic [2:0] e_depth;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic r, logic [3:0] pc, logic [3:0] tgt,
                              logic clr, logic ej, logic [3:0] ea, logic [2:0] ed,
                              logic ef, logic ee, logic eo, logic eu);
    vec_t v;
    v.call = c; v.ret = r; v.pc = pc; v.tgt = tgt; v.clr = clr;
    v.e_jump = ej; v.e_addr = ea; v.e_depth = ed;
    v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic [3:0] pc,
                       input logic [3:0] tgt, input logic clr);
    call = c; ret = r; pc_in = pc; call_target = tgt; err_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    //        c     r     pc     tgt    clr   jump  addr   depth  full  empty ovf   unf
    vecs.push_back(mk(1'b1, 1'b0, 4'd5,  4'd12, 1'b0, 1'b1, 4'd12, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd13, 4'd0,  1'b0, 1'b1, 4'd6,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd1,  4'd9,  1'b0, 1'b1, 4'd9,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd3,  4'd10, 1'b0, 1'b1, 4'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd7,  4'd11, 1'b0, 1'b1, 4'd11, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd12, 4'd0,  1'b0, 1'b1, 4'd8,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd9,  4'd0,  1'b0, 1'b1, 4'd4,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd5,  4'd0,  1'b0, 1'b1, 4'd2,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd15, 4'd3,  1'b0, 1'b1, 4'd3,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd4,  4'd0,  1'b0, 1'b1, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0,  4'd8,  1'b0, 1'b1, 4'd8,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd1,  4'd8,  1'b0, 1'b1, 4'd8,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd2,  4'd8,  1'b0, 1'b1, 4'd8,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd3,  4'd8,  1'b0, 1'b1, 4'd8,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd4,  4'd8,  1'b0, 1'b1, 4'd8,  3'd4, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b0, 1'b1, 4'd5,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b0, 1'b1, 4'd4,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b0, 1'b1, 4'd3,  3'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b0, 1'b1, 4'd2,  3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 4'd8,  4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd8,  4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 4'd8,  4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd1,  4'd6,  1'b0, 1'b1, 4'd6,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'd9,  4'd4,  1'b0, 1'b1, 4'd4,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd5,  4'd0,  1'b0, 1'b1, 4'd10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'd2,  4'd7,  1'b0, 1'b1, 4'd7,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd7,  4'd0,  1'b0, 1'b1, 4'd3,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 4'd3,  4'd5,  1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    #1;
    chk("reset_depth", -1, 8'(depth), 8'd0);
    chk("reset_empty", -1, 8'(empty), 8'd1);
    chk("reset_full", -1, 8'(full), 8'd0);
    chk("reset_ovf", -1, 8'(overflow), 8'd0);
    chk("reset_unf", -1, 8'(underflow), 8'd0);
    chk("reset_jump", -1, 8'(jump_out), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_jump", -1, 8'(jump_out), 8'd0);
    chk("idle_empty", -1, 8'(empty), 8'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].call, vecs[i].ret, vecs[i].pc, vecs[i].tgt, vecs[i].clr);
      #1;
      chk("jump_out", i, 8'(jump_out), 8'(vecs[i].e_jump));
      if (vecs[i].e_jump) chk("jump_addr", i, 8'(jump_addr), 8'(vecs[i].e_addr));
      @(posedge clk);
      #1;
      chk("depth", i, 8'(depth), 8'(vecs[i].e_depth));
      chk("full", i, 8'(full), 8'(vecs[i].e_full));
      chk("empty", i, 8'(empty), 8'(vecs[i].e_empty));
      chk("overflow", i, 8'(overflow), 8'(vecs[i].e_ovf));
      chk("underflow", i, 8'(underflow), 8'(vecs[i].e_unf));
    end

    // asynchronous reset with three entries stacked, no clock edge in between
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'(k), 4'd9, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    #1;
    chk("pre_rst_depth", 100, 8'(depth), 8'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_depth", 100, 8'(depth), 8'd0);
    chk("async_rst_empty", 100, 8'(empty), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // the discarded frames must not be returned to
    drive(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    #1;
    chk("post_rst_ret_jump", 101, 8'(jump_out), 8'd0);
    @(posedge clk);
    #1;
    chk("post_rst_unf", 101, 8'(underflow), 8'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
